vc_fifo_bank: RTL and testbench

- Upstream virtual-channel buffer bank that feeds the weighted round-robin arbiter.
- Holds four independent FIFOs, one per virtual channel (VC0..VC3), filled from a single push port tagged with a 2-bit channel id.
- Drives the per-channel empty flags the arbiter uses for grant decisions, and consumes the arbiter's one-hot pop vector.
- Returns the popped word with a fixed 1-cycle latency.

---
 rtl/vc_fifo_bank_pkg.sv | 23 ++
 rtl/vc_fifo_bank_if.sv | 24 ++
 rtl/vc_fifo_bank_vc_fifo.sv | 66 ++++++
 rtl/vc_fifo_bank.sv | 111 +++++++++++
 tb/tb_vc_fifo_bank.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vc_fifo_bank_pkg.sv
// Shared constants and channel codes for the virtual-channel buffer bank.
package vc_fifo_bank_pkg;

  localparam int unsigned NUM_VC    = 4;
  localparam int unsigned VC_W      = 2;
  localparam int unsigned DEF_DEPTH = 4;

  // Channel codes shared with the arbiter priority table.
  typedef enum logic [VC_W-1:0] {
    VC0 = 2'b00,
    VC1 = 2'b01,
    VC2 = 2'b10,
    VC3 = 2'b11
  } vc_e;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Push/pop bus between the producer, the arbiter and the buffer bank.
interface vc_fifo_bank_if #(
  parameter int unsigned DATA_W = 6
) ();
  import vc_fifo_bank_pkg::*;

  logic              push;
  logic [VC_W-1:0]   push_vc;
  logic [DATA_W-1:0] push_data;
  logic [NUM_VC-1:0] pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;

  modport master (
    output push, push_vc, push_data, pop,
    input  pop_data, pop_valid
  );

  modport slave (
    input  push, push_vc, push_data, pop,
    output pop_data, pop_valid
  );

endinterface

// File: rtl/vc_fifo_bank_vc_fifo.sv
// Single-channel FIFO; push/pop arrive already qualified by the bank.
module vc_fifo
  import vc_fifo_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic                      clk0,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      full
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count_d;

  // Head of queue, read combinationally so the bank can register it.
  assign rdata_c = mem[rptr];

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_d = count;
    unique case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      full        <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count       <= count_d;
      empty       <= (count_d == CW'(0));
      almost_full <= (count_d >= CW'(AF_LEVEL));
      full        <= (count_d == CW'(DEPTH));
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk0) begin
    if (rst && push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// Four-channel VC buffer bank feeding the weighted round-robin arbiter.
module vc_fifo_bank
  import vc_fifo_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic               clk0,
  input  logic               rst,
  input  logic               enb,
  vc_fifo_bank_if.slave      bus,
  output logic               empty_vchannel0,
  output logic               empty_vchannel1,
  output logic               empty_vchannel2,
  output logic               empty_vchannel3,
  output logic [NUM_VC-1:0]  almost_full,
  output logic [NUM_VC-1:0]  full,
  output logic               error
);

  localparam int unsigned CW = ptr_w(DEPTH) + 1;

  logic [DATA_W-1:0] rdata_c [NUM_VC];
  logic [CW-1:0]     cnt     [NUM_VC];
  logic [NUM_VC-1:0] empty_q;
  logic [NUM_VC-1:0] push_ok_c;
  logic [NUM_VC-1:0] pop_ok_c;
  logic [NUM_VC-1:0] fifo_push_c;
  logic [NUM_VC-1:0] fifo_pop_c;
  logic              pop_onehot_c;
  logic              err_c;
  logic [DATA_W-1:0] sel_data_c;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;

  assign empty_vchannel0 = empty_q[0];
  assign empty_vchannel1 = empty_q[1];
  assign empty_vchannel2 = empty_q[2];
  assign empty_vchannel3 = empty_q[3];
  assign bus.pop_data    = pop_data_q;
  assign bus.pop_valid   = pop_valid_q;

  assign pop_onehot_c = (bus.pop != '0) &&
                        ((bus.pop & (bus.pop - NUM_VC'(1))) == '0);

  // Request qualification, error detection and pop-data selection.
  always_comb begin
    push_ok_c  = '0;
    pop_ok_c   = '0;
    err_c      = 1'b0;
    sel_data_c = pop_data_q;
    if (bus.pop != '0 && !pop_onehot_c) err_c = 1'b1;
    for (int n = 0; n < NUM_VC; n++) begin
      if (pop_onehot_c && bus.pop[n]) begin
        if (cnt[n] != CW'(0)) begin
          pop_ok_c[n] = 1'b1;
          sel_data_c  = rdata_c[n];
        end else begin
          err_c = 1'b1;
        end
      end
    end
    for (int n = 0; n < NUM_VC; n++) begin
      if (bus.push && (bus.push_vc == VC_W'(n))) begin
        // A full channel still takes a push when it is popped this cycle.
        if (cnt[n] != CW'(DEPTH) || pop_ok_c[n]) push_ok_c[n] = 1'b1;
        else                                     err_c        = 1'b1;
      end
    end
  end

  assign fifo_push_c = enb ? push_ok_c : '0;
  assign fifo_pop_c  = enb ? pop_ok_c  : '0;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
      .clk0        (clk0),
      .rst         (rst),
      .push        (fifo_push_c[g]),
      .pop         (fifo_pop_c[g]),
      .wdata       (bus.push_data),
      .rdata_c     (rdata_c[g]),
      .count       (cnt[g]),
      .empty       (empty_q[g]),
      .almost_full (almost_full[g]),
      .full        (full[g])
    );
  end

  // Registered pop return path and error pulse.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      error       <= 1'b0;
    end else if (enb) begin
      pop_data_q  <= sel_data_c;
      pop_valid_q <= |pop_ok_c;
      error       <= err_c;
    end else begin
      pop_valid_q <= 1'b0;
      error       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: queue-based model plus directed vectors.
module tb_vc_fifo_bank;
  import vc_fifo_bank_pkg::*;

  localparam int unsigned DATA_W   = 6;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AF_LEVEL = 3;

  logic clk0 = 1'b0;
  logic rst, enb;
  logic e0, e1, e2, e3, error;
  logic [3:0] almost_full, full;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  vc_fifo_bank_if #(.DATA_W(DATA_W)) bus ();

  vc_fifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk0(clk0), .rst(rst), .enb(enb), .bus(bus),
    .empty_vchannel0(e0), .empty_vchannel1(e1),
    .empty_vchannel2(e2), .empty_vchannel3(e3),
    .almost_full(almost_full), .full(full), .error(error)
  );

  always #5 clk0 = ~clk0;

  // Behavioural model: one queue per channel.
  logic [DATA_W-1:0] mq [4][$];
  logic [DATA_W-1:0] exp_pd = '0;
  logic exp_pv = 1'b0, exp_err = 1'b0;

  always @(posedge clk0) begin
    int np, idx, pv;
    bit pop_ok, push_ok, er;
    if (!rst) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      exp_pd = '0; exp_pv = 1'b0; exp_err = 1'b0;
    end else if (enb) begin
      er = 0; pop_ok = 0; idx = 0; pv = 0;
      np = $countones(bus.pop);
      for (int n = 0; n < 4; n++) if (bus.pop[n]) idx = n;
      if (np > 1) er = 1;
      if (np == 1) begin
        if (mq[idx].size() > 0) pop_ok = 1; else er = 1;
      end
      push_ok = bus.push && (mq[bus.push_vc].size() < DEPTH ||
                             (pop_ok && idx == int'(bus.push_vc)));
      if (bus.push && !push_ok) er = 1;
      if (pop_ok) begin exp_pd = mq[idx].pop_front(); pv = 1; end
      if (push_ok) mq[bus.push_vc].push_back(bus.push_data);
      exp_pv = (pv != 0); exp_err = er;
    end else begin
      exp_pv = 1'b0; exp_err = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_flags(input int kind);
    logic [3:0] f = '0;
    for (int n = 0; n < 4; n++) begin
      case (kind)
        0: f[n] = (mq[n].size() == 0);
        1: f[n] = (mq[n].size() >= AF_LEVEL);
        default: f[n] = (mq[n].size() == DEPTH);
      endcase
    end
    return f;
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk0) begin
    if (check_en) begin
      chk("empty",       32'({e3, e2, e1, e0}), 32'(exp_flags(0)));
      chk("almost_full", 32'(almost_full),      32'(exp_flags(1)));
      chk("full",        32'(full),             32'(exp_flags(2)));
      chk("pop_valid",   32'(bus.pop_valid),    32'(exp_pv));
      chk("pop_data",    32'(bus.pop_data),     32'(exp_pd));
      chk("error",       32'(error),            32'(exp_err));
    end
  end

  // Apply one request for one clock edge, then return to idle.
  task automatic step(input logic p, input logic [1:0] vc, input logic [5:0] d,
                      input logic [3:0] pp);
    bus.push = p; bus.push_vc = vc; bus.push_data = d; bus.pop = pp;
    @(posedge clk0); #2;
    bus.push = 1'b0; bus.pop = '0;
  endtask

  logic [3:0] saved_e;

  initial begin
    rst = 1'b0; enb = 1'b1;
    bus.push = 1'b1; bus.push_vc = 2'd2; bus.push_data = 6'h05; bus.pop = '0;
    @(posedge clk0); #2;
    check_en = 1'b1;
    @(posedge clk0); #2;
    chk("rst_empty", 32'({e3, e2, e1, e0}), 32'hF);
    chk("rst_full",  32'(full), 32'h0);
    chk("rst_pv",    32'(bus.pop_valid), 32'h0);
    chk("rst_err",   32'(error), 32'h0);
    rst = 1'b1; bus.push = 1'b0;
    step(0, 2'd0, 6'h00, 4'b0000);
    chk("post_rst_empty", 32'({e3, e2, e1, e0}), 32'hF);

    // Fill and drain VC2.
    step(1, 2'd2, 6'h11, 4'b0000);
    step(1, 2'd2, 6'h12, 4'b0000);
    step(1, 2'd2, 6'h13, 4'b0000);
    chk("vc2_af3", 32'(almost_full), 32'h4);
    step(1, 2'd2, 6'h14, 4'b0000);
    chk("vc2_full4", 32'(full), 32'h4);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'd0, 6'h00, 4'b0100);
      chk("vc2_pop_data", 32'(bus.pop_data), 32'(6'h11 + i));
      chk("vc2_pop_valid", 32'(bus.pop_valid), 32'h1);
    end
    chk("vc2_empty", 32'(e2), 32'h1);

    // Wrap-around on VC0: values 1..9 in three rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) step(1, 2'd0, 6'(3 * r + i + 1), 4'b0000);
      for (int i = 0; i < 3; i++) begin
        step(0, 2'd0, 6'h00, 4'b0001);
        chk("wrap_data", 32'(bus.pop_data), 32'(3 * r + i + 1));
      end
    end

    // Pop on empty VC1.
    step(0, 2'd0, 6'h00, 4'b0010);
    chk("pop_empty_err", 32'(error), 32'h1);
    chk("pop_empty_pv",  32'(bus.pop_valid), 32'h0);

    // Overflow push to VC3.
    for (int i = 0; i < 4; i++) step(1, 2'd3, 6'(6'h30 + i), 4'b0000);
    step(1, 2'd3, 6'h3F, 4'b0000);
    chk("ovf_err",  32'(error), 32'h1);
    chk("ovf_full", 32'(full), 32'h8);
    for (int i = 0; i < 4; i++) begin
      step(0, 2'd0, 6'h00, 4'b1000);
      chk("vc3_data", 32'(bus.pop_data), 32'(6'h30 + i));
    end
    chk("vc3_empty", 32'(e3), 32'h1);

    // Fill VC1, then a multi-hot pop.
    for (int i = 0; i < 4; i++) step(1, 2'd1, 6'(6'h20 + i), 4'b0000);
    step(0, 2'd0, 6'h00, 4'b0011);
    chk("multi_err", 32'(error), 32'h1);
    chk("multi_full", 32'(full), 32'h2);

    // Same-cycle push and pop on full VC1.
    step(1, 2'd1, 6'h24, 4'b0010);
    chk("sim_full_full", 32'(full), 32'h2);
    chk("sim_full_err",  32'(error), 32'h0);
    chk("sim_full_data", 32'(bus.pop_data), 32'h20);

    // Same-cycle push and pop on empty VC0.
    step(1, 2'd0, 6'h2A, 4'b0001);
    chk("sim_empty_err",  32'(error), 32'h1);
    chk("sim_empty_e0",   32'(e0), 32'h0);
    chk("sim_empty_hold", 32'(bus.pop_data), 32'h20);
    step(0, 2'd0, 6'h00, 4'b0001);
    chk("sim_empty_data", 32'(bus.pop_data), 32'h2A);

    // Enable held low with requests active.
    saved_e = {e3, e2, e1, e0};
    enb = 1'b0;
    bus.push = 1'b1; bus.push_vc = 2'd2; bus.push_data = 6'h3C; bus.pop = 4'b0010;
    repeat (5) begin @(posedge clk0); #2; end
    chk("enb_empty", 32'({e3, e2, e1, e0}), 32'(saved_e));
    chk("enb_pv",    32'(bus.pop_valid), 32'h0);
    bus.push = 1'b0; bus.pop = '0;
    enb = 1'b1;
    step(0, 2'd0, 6'h00, 4'b0010);
    chk("resume_data", 32'(bus.pop_data), 32'h21);

    // Reset with data present discards it.
    rst = 1'b0;
    step(0, 2'd0, 6'h00, 4'b0000);
    rst = 1'b1;
    step(0, 2'd0, 6'h00, 4'b0010);
    chk("midrst_err", 32'(error), 32'h1);
    chk("midrst_empty", 32'({e3, e2, e1, e0}), 32'hF);

    step(0, 2'd0, 6'h00, 4'b0000);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
